// File: rtl/iterative_divider.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle.
// Divide-by-zero and signed overflow bypass the loop and finish in one cycle.
module iterative_divider #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              startE,
  input  logic [1:0]        div_opcode,
  input  logic [DATA_W-1:0] operand1,
  input  logic [DATA_W-1:0] operand2,
  output logic [DATA_W-1:0] result_divide,
  output logic              done,
  output logic              div_use
);
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [DATA_W-1:0] MIN_NEG  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] ALL_ONES = '1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_W - 1);

  // Two's complement negation; the most negative value maps to itself.
  function automatic logic [DATA_W-1:0] cond_negate(input logic [DATA_W-1:0] v,
                                                    input logic neg);
    cond_negate = neg ? (~v + DATA_W'(1)) : v;
  endfunction

  logic [1:0]          state;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   q_r;
  logic [DATA_W-1:0]   d_r;
  logic [DATA_W:0]     rem_r;
  logic                rem_sel_r;
  logic                q_neg_r;
  logic                r_neg_r;
  logic                spec_r;
  logic [DATA_W-1:0]   spec_val_r;
  logic [DATA_W-1:0]   res_r;

  logic signed [DATA_W-1:0] op1_s;
  logic signed [DATA_W-1:0] op2_s;
  logic                is_signed;
  logic                is_rem;
  logic                a_neg;
  logic                b_neg;
  logic                div_zero;
  logic                ovf;
  logic                special;
  logic [DATA_W-1:0]   spec_val;
  logic [DATA_W+1:0]   rem_shift;
  logic [DATA_W+1:0]   diff;
  logic                fits;
  logic [DATA_W-1:0]   final_val;

  assign op1_s     = operand1;
  assign op2_s     = operand2;
  assign is_signed = ~div_opcode[0];
  assign is_rem    = div_opcode[1];
  assign a_neg     = is_signed && (op1_s < 0);
  assign b_neg     = is_signed && (op2_s < 0);
  assign div_zero  = (operand2 == '0);
  assign ovf       = is_signed && (operand1 == MIN_NEG) && (operand2 == ALL_ONES);
  assign special   = div_zero || ovf;
  assign spec_val  = div_zero ? (is_rem ? operand1 : ALL_ONES)
                              : (is_rem ? '0 : MIN_NEG);

  // Restoring step: shift in the next dividend bit, keep the difference if non-negative.
  assign rem_shift = {rem_r, q_r[DATA_W-1]};
  assign diff      = rem_shift - {2'b00, d_r};
  assign fits      = ~diff[DATA_W+1];

  assign final_val = spec_r    ? spec_val_r
                   : rem_sel_r ? cond_negate(rem_r[DATA_W-1:0], r_neg_r)
                               : cond_negate(q_r, q_neg_r);

  assign done          = (state == DONE);
  assign div_use       = (state == CALC) || ((state == IDLE) && startE);
  assign result_divide = done ? final_val : res_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      q_r        <= '0;
      d_r        <= '0;
      rem_r      <= '0;
      rem_sel_r  <= 1'b0;
      q_neg_r    <= 1'b0;
      r_neg_r    <= 1'b0;
      spec_r     <= 1'b0;
      spec_val_r <= '0;
      res_r      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (startE) begin
            rem_sel_r  <= is_rem;
            q_neg_r    <= a_neg ^ b_neg;
            r_neg_r    <= a_neg;
            q_r        <= cond_negate(operand1, a_neg);
            d_r        <= cond_negate(operand2, b_neg);
            rem_r      <= '0;
            cnt        <= '0;
            spec_r     <= special;
            spec_val_r <= spec_val;
            state      <= special ? DONE : CALC;
          end
        end
        CALC: begin
          q_r   <= {q_r[DATA_W-2:0], fits};
          rem_r <= fits ? diff[DATA_W:0] : rem_shift[DATA_W:0];
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) state <= DONE;
        end
        DONE: begin
          res_r <= final_val;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iterative_divider.sv
// Scoreboard bench for iterative_divider: stimulus pushes expected result and done cycle,
// a negedge monitor pops and compares on every done pulse.
module tb_iterative_divider;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        startE = 1'b0;
  logic [1:0]  div_opcode = 2'b00;
  logic [31:0] operand1 = '0;
  logic [31:0] operand2 = '0;
  logic [31:0] result_divide;
  logic        done;
  logic        div_use;

  always #5 clk = ~clk;

  iterative_divider dut (
    .clk(clk),
    .rst(rst),
    .startE(startE),
    .div_opcode(div_opcode),
    .operand1(operand1),
    .operand2(operand2),
    .result_divide(result_divide),
    .done(done),
    .div_use(div_use)
  );

  localparam logic [31:0] MIN_NEG = 32'h8000_0000;
  localparam logic [31:0] NEG_ONE = 32'hFFFF_FFFF;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] sb_val[$];
  int          sb_cyc[$];
  string       sb_name[$];
  logic [31:0] last_res = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: RISC-V M-extension semantics with SV native division.
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    case (op)
      2'b00: begin
        if (b == 0) ref_div = NEG_ONE;
        else if (a == MIN_NEG && b == NEG_ONE) ref_div = MIN_NEG;
        else ref_div = 32'(sa / sb);
      end
      2'b01: ref_div = (b == 0) ? NEG_ONE : a / b;
      2'b10: begin
        if (b == 0) ref_div = a;
        else if (a == MIN_NEG && b == NEG_ONE) ref_div = '0;
        else ref_div = 32'(sa % sb);
      end
      default: ref_div = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [1:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    return (b == 0) || (!op[0] && a == MIN_NEG && b == NEG_ONE);
  endfunction

  // Called #1 after a rising edge; that cycle is the start cycle.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input string name);
    startE     = 1'b1;
    div_opcode = op;
    operand1   = a;
    operand2   = b;
    sb_val.push_back(ref_div(op, a, b));
    sb_cyc.push_back(cyc + (is_special(op, a, b) ? 1 : 33));
    sb_name.push_back(name);
    @(posedge clk); #1;
    startE     = 1'b0;
    div_opcode = 2'($urandom);
    operand1   = $urandom;
    operand2   = $urandom;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb_val.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check("drain_timeout", 32'(sb_val.size()), 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (done) begin
          check("done_div_use", 32'(div_use), 32'd0);
          if (sb_val.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL spurious_done: got done=1 with nothing outstanding, required done=0 (cycle %0d)", cyc);
          end else begin
            check({sb_name[0], "_value"}, result_divide, sb_val[0]);
            check({sb_name[0], "_cycle"}, 32'(cyc), 32'(sb_cyc[0]));
            last_res = sb_val[0];
            void'(sb_val.pop_front());
            void'(sb_cyc.pop_front());
            void'(sb_name.pop_front());
          end
        end else begin
          check("result_hold", result_divide, last_res);
          if (sb_val.size() != 0) begin
            check("div_use_busy", 32'(div_use), 32'd1);
            if (cyc >= sb_cyc[0]) begin
              n_cmp++;
              n_bad++;
              $display("FAIL %s_missing_done: got done=0 at cycle %0d, required done=1 by cycle %0d",
                       sb_name[0], cyc, sb_cyc[0]);
              void'(sb_val.pop_front());
              void'(sb_cyc.pop_front());
              void'(sb_name.pop_front());
            end
          end else begin
            check("div_use_idle", 32'(div_use), 32'(startE));
          end
        end
      end
    end
  end

  initial begin : stimulus
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_result", result_divide, 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_div_use", 32'(div_use), 32'd0);
    @(posedge clk); #1;

    issue(2'b01, 32'd100, 32'd7, "divu_100_7");             drain();
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");         drain();
    issue(2'b00, 32'hFFFF_FFF9, 32'd2, "div_m7_2");         drain();
    issue(2'b00, 32'd5, 32'd0, "div_5_0");                  drain();
    issue(2'b11, 32'd5, 32'd0, "remu_5_0");                 drain();
    issue(2'b00, MIN_NEG, NEG_ONE, "div_ovf");              drain();
    issue(2'b10, MIN_NEG, NEG_ONE, "rem_ovf");              drain();
    issue(2'b01, MIN_NEG, NEG_ONE, "divu_min_m1");          drain();

    // Restart attempt during CALC must be ignored.
    issue(2'b01, 32'd1000, 32'd9, "divu_ignore_restart");
    idle(9);
    startE     = 1'b1;
    div_opcode = 2'b01;
    operand1   = 32'd77;
    operand2   = 32'd5;
    @(posedge clk); #1;
    startE = 1'b0;
    drain();

    // Reset in the middle of CALC aborts without a done pulse.
    issue(2'b01, 32'd12345, 32'd17, "divu_abort");
    idle(9);
    rst = 1'b1;
    sb_val.delete();
    sb_cyc.delete();
    sb_name.delete();
    last_res = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(5);
    issue(2'b01, 32'd9, 32'd3, "divu_9_3_after_reset");     drain();

    for (int i = 0; i < 120; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = MIN_NEG; b = NEG_ONE; end
        2: b = 32'($urandom_range(1, 15));
        3: begin a = 32'($urandom_range(0, 255)); b = 32'($urandom_range(1, 20)); end
        4: b = 32'd0 - 32'($urandom_range(1, 9));
        5: begin a = MIN_NEG; b = 32'($urandom_range(1, 7)); end
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      issue(op, a, b, "random");
      drain();
    end

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
